// File: rtl/lif_pkg.sv
// Shared types, constants and helpers for the leaky integrate-and-fire neuron family.
// Imported by the neuron top and the synaptic adder.
package lif_pkg;

    typedef enum logic [0:0] {
        ST_INTEG  = 1'b0,
        ST_REFRAC = 1'b1
    } lif_state_e;

    localparam logic RM_ZERO = 1'b0;
    localparam logic RM_SUB  = 1'b1;

    // Config register offsets above the last weight address
    localparam int CFG_THRESH = 0;
    localparam int CFG_CTRL   = 1;

    // Working width for the wide signed potential before clamping
    localparam int CLAMP_W = 32;

    // Clamp a signed wide value into the unsigned range [0, 2^vw-1]
    function automatic logic [CLAMP_W-1:0] sat_clamp(input logic signed [CLAMP_W-1:0] x,
                                                     input int vw);
        logic [CLAMP_W-1:0] max_v;
        max_v = (CLAMP_W'(1) << vw) - CLAMP_W'(1);
        if (x[CLAMP_W-1]) begin
            sat_clamp = '0;
        end else if ($unsigned(x) > max_v) begin
            sat_clamp = max_v;
        end else begin
            sat_clamp = $unsigned(x);
        end
    endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// Combinational gated signed sum of synaptic weights; weight i contributes only
// when spike i is set.
module lif_syn_sum
    import lif_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = 4,
    parameter int SYN_W   = W_WIDTH + $clog2(N_IN) + 1
) (
    input  logic [N_IN-1:0][W_WIDTH-1:0] weights,
    input  logic [N_IN-1:0]              spikes,
    output logic signed [SYN_W-1:0]      sum
);

    logic signed [SYN_W-1:0] acc_s;

    // Accumulate the sign-extended weights of every active input
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spikes[i]) begin
                acc_s = acc_s + SYN_W'(signed'(weights[i]));
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign sum = acc_s;

endmodule

// File: rtl/lif_neuron_cfg.sv
// Configurable leaky integrate-and-fire neuron: weighted spike inputs plus direct
// current, shift leak, programmable threshold, reset mode and refractory period.
module lif_neuron_cfg
    import lif_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 4,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC_W   = 3,
    parameter int THRESH_RST = 128,
    parameter int WEIGHT_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [V_WIDTH-1:0]         cur_in,
    input  logic [N_IN-1:0]            spike_in,
    input  logic                       cfg_we,
    input  logic [$clog2(N_IN+2)-1:0]  cfg_addr,
    input  logic [V_WIDTH-1:0]         cfg_data,
    output logic                       spike,
    output logic [V_WIDTH-1:0]         state,
    output logic                       refrac
);

    localparam int ADDR_W = $clog2(N_IN + 2);
    localparam int SYN_W  = W_WIDTH + $clog2(N_IN) + 1;

    logic [N_IN-1:0][W_WIDTH-1:0] weight_r;
    logic [V_WIDTH-1:0]           thresh_r;
    logic [REFRAC_W:0]            ctrl_r;

    lif_state_e                   fsm_r;
    logic [REFRAC_W-1:0]          cnt_r;
    logic [V_WIDTH-1:0]           state_r;
    logic                         spike_r;
    logic                         refrac_r;

    logic signed [SYN_W-1:0]      syn_s;
    logic [V_WIDTH-1:0]           v_leak_s;
    logic signed [CLAMP_W-1:0]    v_wide_s;
    logic [V_WIDTH-1:0]           v_next_s;
    logic [V_WIDTH-1:0]           v_sub_s;
    logic                         fire_s;
    logic                         reset_mode_s;
    logic [REFRAC_W-1:0]          refrac_len_s;

    lif_syn_sum #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .SYN_W   (SYN_W)
    ) u_syn_sum (
        .weights (weight_r),
        .spikes  (spike_in),
        .sum     (syn_s)
    );

    assign reset_mode_s = ctrl_r[0];
    assign refrac_len_s = ctrl_r[REFRAC_W:1];

    // Leak, integrate and clamp; the sum is formed wide so negative synapses cannot wrap
    always_comb begin
        v_leak_s = state_r - (state_r >> LEAK_SHIFT);
        v_wide_s = signed'(CLAMP_W'(v_leak_s)) + signed'(CLAMP_W'(cur_in)) + CLAMP_W'(syn_s);
        v_next_s = V_WIDTH'(sat_clamp(v_wide_s, V_WIDTH));
        fire_s   = (v_next_s >= thresh_r);
        v_sub_s  = v_next_s - thresh_r;
    end

    // Config register file; writes land on the edge so the same cycle sees old values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                weight_r[i] <= W_WIDTH'(WEIGHT_RST);
            end
            thresh_r <= V_WIDTH'(THRESH_RST);
            ctrl_r   <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    weight_r[i] <= cfg_data[W_WIDTH-1:0];
                end
            end
            if (cfg_addr == ADDR_W'(N_IN + CFG_THRESH)) begin
                thresh_r <= cfg_data;
            end
            if (cfg_addr == ADDR_W'(N_IN + CFG_CTRL)) begin
                ctrl_r <= cfg_data[REFRAC_W:0];
            end
        end
    end

    // Neuron FSM with registered potential, spike pulse and refractory flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r    <= ST_INTEG;
            cnt_r    <= '0;
            state_r  <= '0;
            spike_r  <= 1'b0;
            refrac_r <= 1'b0;
        end else if (!en) begin
            spike_r <= 1'b0;
        end else begin
            case (fsm_r)
                ST_INTEG: begin
                    if (fire_s) begin
                        spike_r <= 1'b1;
                        state_r <= (reset_mode_s == RM_SUB) ? v_sub_s : '0;
                        if (refrac_len_s != '0) begin
                            fsm_r    <= ST_REFRAC;
                            cnt_r    <= refrac_len_s;
                            refrac_r <= 1'b1;
                        end
                    end else begin
                        spike_r <= 1'b0;
                        state_r <= v_next_s;
                    end
                end
                ST_REFRAC: begin
                    spike_r <= 1'b0;
                    state_r <= v_leak_s;
                    cnt_r   <= cnt_r - REFRAC_W'(1);
                    // A zero count cannot be loaded, but treat it as expiry rather than wrap
                    if (cnt_r <= REFRAC_W'(1)) begin
                        fsm_r    <= ST_INTEG;
                        refrac_r <= 1'b0;
                    end
                end
                default: begin
                    fsm_r    <= ST_INTEG;
                    spike_r  <= 1'b0;
                    refrac_r <= 1'b0;
                end
            endcase
        end
    end

    assign spike  = spike_r;
    assign state  = state_r;
    assign refrac = refrac_r;

endmodule

// File: tb/tb_lif_neuron_cfg.sv
// Directed, table-driven bench for lif_neuron_cfg with hand sequences for async
// reset and same-cycle config writes.
module tb_lif_neuron_cfg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] cur_in;
    logic [3:0] spike_in;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       spike;
    logic [7:0] state;
    logic       refrac;

    int n_pass;
    int n_total;

    typedef struct {
        logic       en;
        logic [7:0] cur;
        logic [3:0] sp;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic       e_spike;
        logic [7:0] e_state;
        logic       e_refrac;
    } vec_t;

    vec_t vecs[32];
    int   nv;

    lif_neuron_cfg dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cur_in   (cur_in),
        .spike_in (spike_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .spike    (spike),
        .state    (state),
        .refrac   (refrac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input int cur, input logic [3:0] sp,
                                input logic we, input int addr, input int data,
                                input logic es, input int est, input logic er);
        vec_t v;
        v.en = e; v.cur = 8'(cur); v.sp = sp; v.we = we;
        v.addr = 3'(addr); v.data = 8'(data);
        v.e_spike = es; v.e_state = 8'(est); v.e_refrac = er;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nv] = v;
        nv++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector at the falling edge, check outputs just after the rising edge
    task automatic apply(input string label, input vec_t v);
        @(negedge clk);
        en = v.en; cur_in = v.cur; spike_in = v.sp;
        cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data;
        @(posedge clk);
        #1;
        chk({label, "_state"},  int'(state),  int'(v.e_state));
        chk({label, "_spike"},  int'(spike),  int'(v.e_spike));
        chk({label, "_refrac"}, int'(refrac), int'(v.e_refrac));
    endtask

    initial begin
        n_pass = 0; n_total = 0; nv = 0;
        rst = 1'b1; en = 1'b0; cur_in = 8'd0; spike_in = 4'd0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;

        // integrate then fire, reset-to-zero
        add(mk(1'b1, 100, 4'h0, 1'b0, 0, 0,   1'b0, 100, 1'b0));
        add(mk(1'b1, 100, 4'h0, 1'b0, 0, 0,   1'b1, 0,   1'b0));
        add(mk(1'b0, 100, 4'h0, 1'b0, 0, 0,   1'b0, 0,   1'b0));
        // subtract-threshold mode
        add(mk(1'b0, 0,   4'h0, 1'b1, 5, 1,   1'b0, 0,   1'b0));
        add(mk(1'b1, 100, 4'h0, 1'b0, 0, 0,   1'b0, 100, 1'b0));
        add(mk(1'b1, 100, 4'h0, 1'b0, 0, 0,   1'b1, 22,  1'b0));
        add(mk(1'b0, 100, 4'h0, 1'b0, 0, 0,   1'b0, 22,  1'b0));
        // all weights -8, clamp at zero and at max
        for (int a = 0; a < 4; a++) begin
            add(mk(1'b0, 0, 4'h0, 1'b1, a, 8'h08, 1'b0, 22, 1'b0));
        end
        add(mk(1'b1, 0,   4'h0, 1'b0, 0, 0,   1'b0, 11,  1'b0));
        add(mk(1'b1, 0,   4'hF, 1'b0, 0, 0,   1'b0, 0,   1'b0));
        add(mk(1'b1, 20,  4'h1, 1'b0, 0, 0,   1'b0, 12,  1'b0));
        add(mk(1'b0, 0,   4'h0, 1'b1, 4, 255, 1'b0, 12,  1'b0));
        add(mk(1'b1, 255, 4'h0, 1'b0, 0, 0,   1'b1, 0,   1'b0));
        // refractory length 3, subtract mode; inputs ignored while refractory
        add(mk(1'b0, 0,   4'h0, 1'b1, 4, 128, 1'b0, 0,   1'b0));
        add(mk(1'b0, 0,   4'h0, 1'b1, 5, 7,   1'b0, 0,   1'b0));
        add(mk(1'b1, 200, 4'h0, 1'b0, 0, 0,   1'b1, 72,  1'b1));
        add(mk(1'b1, 200, 4'hF, 1'b0, 0, 0,   1'b0, 36,  1'b1));
        add(mk(1'b0, 200, 4'hF, 1'b0, 0, 0,   1'b0, 36,  1'b1));
        add(mk(1'b1, 200, 4'hF, 1'b0, 0, 0,   1'b0, 18,  1'b1));
        add(mk(1'b1, 200, 4'hF, 1'b0, 0, 0,   1'b0, 9,   1'b0));
        add(mk(1'b1, 0,   4'h0, 1'b0, 0, 0,   1'b0, 5,   1'b0));
        // out-of-range addresses must not touch any register
        add(mk(1'b0, 0,   4'h0, 1'b1, 6, 0,   1'b0, 5,   1'b0));
        add(mk(1'b0, 0,   4'h0, 1'b1, 7, 0,   1'b0, 5,   1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",  int'(state),  0);
        chk("reset_spike",  int'(spike),  0);
        chk("reset_refrac", int'(refrac), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset mid-refractory with a pending threshold write
        apply("pre_rst", mk(1'b1, 215, 4'h0, 1'b0, 0, 0, 1'b1, 90, 1'b1));
        @(negedge clk);
        en = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd50;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state",  int'(state),  0);
        chk("async_rst_spike",  int'(spike),  0);
        chk("async_rst_refrac", int'(refrac), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; en = 1'b0;
        apply("post_rst_a", mk(1'b1, 100, 4'hF, 1'b0, 0, 0, 1'b0, 104, 1'b0));
        apply("post_rst_b", mk(1'b1, 75,  4'h1, 1'b0, 0, 0, 1'b1, 0,   1'b0));
        apply("post_rst_c", mk(1'b1, 0,   4'h0, 1'b0, 0, 0, 1'b0, 0,   1'b0));

        // Weight write in the same cycle as its spike uses the old weight
        apply("samecyc_a", mk(1'b1, 0, 4'h1, 1'b1, 0, 7, 1'b0, 1, 1'b0));
        apply("samecyc_b", mk(1'b1, 0, 4'h1, 1'b0, 0, 0, 1'b0, 8, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
